// File: rtl/pool_ctrl_gen.sv
// pool_ctrl_gen: K x K stride-K pooling address/control sequencer.
// Walks ch/oy/ox/ky/kx and delays strobes by the source RAM latency.
module pool_ctrl_gen #(
  parameter int IN_W    = 10,
  parameter int IN_H    = 10,
  parameter int K       = 2,
  parameter int CH      = 16,
  parameter int RD_LAT  = 1,
  parameter int RADDR_W = 11,
  parameter int WADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pool_start,
  input  logic               pool_mode,
  input  logic               pool_stall,
  input  logic               pool_abort,
  output logic [RADDR_W-1:0] src_raddr,
  output logic               src_rd_en,
  output logic [WADDR_W-1:0] dst_waddr,
  output logic               dst_wr_en,
  output logic               pool_clr,
  output logic               pool_mode_o,
  output logic               pool_busy,
  output logic               pool_done
);

  localparam int OUT_W = IN_W / K;
  localparam int OUT_H = IN_H / K;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW = $clog2(RD_LAT + 3);

  if (K < 2 || K > 4) begin : g_bad_k
    $error("pool_ctrl_gen: K must be 2..4");
  end
  if ((IN_W % K) != 0 || (IN_H % K) != 0) begin : g_bad_map
    $error("pool_ctrl_gen: IN_W and IN_H must be multiples of K");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("pool_ctrl_gen: RD_LAT must be 1..3");
  end
  if (CH < 1) begin : g_bad_ch
    $error("pool_ctrl_gen: CH must be at least 1");
  end
  if ((longint'(CH) * IN_W * IN_H) > (longint'(1) << RADDR_W))
  begin : g_bad_raw
    $error("pool_ctrl_gen: RADDR_W too small");
  end
  if ((longint'(CH) * OUT_W * OUT_H) > (longint'(1) << WADDR_W))
  begin : g_bad_waw
    $error("pool_ctrl_gen: WADDR_W too small");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0] kx_q, ky_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic [CW-1:0] ch_q;
  logic [DW-1:0] drn_q;

  logic kx_l, ky_l, ox_l, oy_l, ch_l;
  logic last, issue, start_ok, first_el;

  logic [RADDR_W-1:0] raddr_n;
  logic [WADDR_W-1:0] waddr_n;

  logic [RD_LAT:0]    clr_sr;
  logic [RD_LAT+1:0]  wr_sr;
  logic [WADDR_W-1:0] waddr_sr [RD_LAT+2];

  assign kx_l = (kx_q == KW'(K - 1));
  assign ky_l = (ky_q == KW'(K - 1));
  assign ox_l = (ox_q == XW'(OUT_W - 1));
  assign oy_l = (oy_q == YW'(OUT_H - 1));
  assign ch_l = (ch_q == CW'(CH - 1));
  assign last = kx_l & ky_l & ox_l & oy_l & ch_l;
  assign first_el = (kx_q == '0) & (ky_q == '0);

  assign issue = (state_q == RUN) & ~pool_stall & ~pool_abort;
  assign start_ok = (state_q == IDLE) & pool_start & ~pool_abort;

  assign raddr_n = RADDR_W'(
    32'(ch_q) * 32'(IN_W * IN_H) +
    (32'(oy_q) * 32'(K) + 32'(ky_q)) * 32'(IN_W) +
    32'(ox_q) * 32'(K) + 32'(kx_q));

  assign waddr_n = WADDR_W'(
    32'(ch_q) * 32'(OUT_W * OUT_H) +
    32'(oy_q) * 32'(OUT_W) + 32'(ox_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN holds until the last write strobe has left the delay line
  always_comb begin
    state_d = state_q;
    if (pool_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (pool_start) state_d = RUN;
        RUN:     if (issue && last) state_d = DRAIN;
        DRAIN:   if (drn_q == DW'(RD_LAT + 1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drn_q <= '0;
    end else if (state_q == DRAIN && !pool_abort) begin
      drn_q <= drn_q + 1'b1;
    end else begin
      drn_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      ch_q <= '0;
    end else if (start_ok || pool_abort) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      ch_q <= '0;
    end else if (issue) begin
      kx_q <= kx_l ? '0 : kx_q + 1'b1;
      if (kx_l) begin
        ky_q <= ky_l ? '0 : ky_q + 1'b1;
        if (ky_l) begin
          ox_q <= ox_l ? '0 : ox_q + 1'b1;
          if (ox_l) begin
            oy_q <= oy_l ? '0 : oy_q + 1'b1;
            if (oy_l) begin
              ch_q <= ch_l ? '0 : ch_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_mode_o <= 1'b0;
    end else if (start_ok) begin
      pool_mode_o <= pool_mode;
    end
  end

  // markers ride with each issued element; abort flushes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_rd_en <= 1'b0;
      src_raddr <= '0;
      clr_sr    <= '0;
      wr_sr     <= '0;
    end else if (pool_abort) begin
      src_rd_en <= 1'b0;
      clr_sr    <= '0;
      wr_sr     <= '0;
    end else begin
      src_rd_en <= issue;
      if (issue) src_raddr <= raddr_n;
      clr_sr <= {clr_sr[RD_LAT-1:0], issue & first_el};
      wr_sr  <= {wr_sr[RD_LAT:0], issue & kx_l & ky_l};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT + 2; i++) waddr_sr[i] <= '0;
    end else begin
      waddr_sr[0] <= waddr_n;
      for (int i = 1; i < RD_LAT + 2; i++) waddr_sr[i] <= waddr_sr[i-1];
    end
  end

  assign pool_clr  = clr_sr[RD_LAT];
  assign dst_wr_en = wr_sr[RD_LAT+1];
  assign dst_waddr = waddr_sr[RD_LAT+1];
  assign pool_busy = (state_q != IDLE);
  assign pool_done = (state_q == DONE);

endmodule

// File: tb/tb_pool_ctrl_gen.sv
// tb_pool_ctrl_gen: directed bench for pool_ctrl_gen, default and
// 28x28/6ch/RD_LAT=2 configurations.
module tb_pool_ctrl_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_mode, a_stall, a_abort;
  logic [10:0] a_raddr;
  logic [8:0]  a_waddr;
  logic        a_rd_en, a_wr_en, a_clr, a_mode_o, a_busy, a_done_o;

  logic        b_start, b_mode, b_stall, b_abort;
  logic [12:0] b_raddr;
  logic [10:0] b_waddr;
  logic        b_rd_en, b_wr_en, b_clr, b_mode_o, b_busy, b_done_o;

  pool_ctrl_gen u_a (
    .clk(clk), .rst_n(rst_n),
    .pool_start(a_start), .pool_mode(a_mode),
    .pool_stall(a_stall), .pool_abort(a_abort),
    .src_raddr(a_raddr), .src_rd_en(a_rd_en),
    .dst_waddr(a_waddr), .dst_wr_en(a_wr_en),
    .pool_clr(a_clr), .pool_mode_o(a_mode_o),
    .pool_busy(a_busy), .pool_done(a_done_o)
  );

  pool_ctrl_gen #(
    .IN_W(28), .IN_H(28), .K(2), .CH(6),
    .RD_LAT(2), .RADDR_W(13), .WADDR_W(11)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .pool_start(b_start), .pool_mode(b_mode),
    .pool_stall(b_stall), .pool_abort(b_abort),
    .src_raddr(b_raddr), .src_rd_en(b_rd_en),
    .dst_waddr(b_waddr), .dst_wr_en(b_wr_en),
    .pool_clr(b_clr), .pool_mode_o(b_mode_o),
    .pool_busy(b_busy), .pool_done(b_done_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  int a_rd, a_wr, a_clr_n, a_dn, a_err, a_merr;
  int a_last_wa, a_last_wr, a_done_cyc, a_f_clr, a_f_wr, a_f_wa;
  int a_ra [8];
  logic a_exp_mode;

  int b_rd, b_wr, b_clr_n, b_dn, b_err;
  int b_last_ra, b_last_wa, b_last_wr, b_done_cyc, b_f_clr, b_f_wr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_ra(input int n, input int inw,
                                input int inh, input int k,
                                input int ow, input int oh);
    int m, kx, ky, ox, oy, ch;
    m = n;
    kx = m % k;  m = m / k;
    ky = m % k;  m = m / k;
    ox = m % ow; m = m / ow;
    oy = m % oh; ch = m / oh;
    return ch * inw * inh + (oy * k + ky) * inw + ox * k + kx;
  endfunction

  task automatic clr_stats();
    a_rd = 0; a_wr = 0; a_clr_n = 0; a_dn = 0; a_err = 0; a_merr = 0;
    a_last_wa = -1; a_last_wr = -1; a_done_cyc = -1;
    a_f_clr = -1; a_f_wr = -1; a_f_wa = -1;
    for (int i = 0; i < 8; i++) a_ra[i] = -1;
    b_rd = 0; b_wr = 0; b_clr_n = 0; b_dn = 0; b_err = 0;
    b_last_ra = -1; b_last_wa = -1; b_last_wr = -1; b_done_cyc = -1;
    b_f_clr = -1; b_f_wr = -1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (a_rd_en) begin
      if (a_rd < 8) a_ra[a_rd] = int'(a_raddr);
      if (int'(a_raddr) != exp_ra(a_rd, 10, 10, 2, 5, 5)) a_err++;
      a_rd++;
    end
    if (a_clr) begin
      if (a_f_clr < 0) a_f_clr = cyc_n;
      a_clr_n++;
    end
    if (a_wr_en) begin
      if (a_f_wr < 0) begin a_f_wr = cyc_n; a_f_wa = int'(a_waddr); end
      if (int'(a_waddr) != a_wr) a_err++;
      a_last_wa = int'(a_waddr);
      a_last_wr = cyc_n;
      a_wr++;
    end
    if (a_done_o) begin a_dn++; a_done_cyc = cyc_n; end
    if (a_busy && a_mode_o !== a_exp_mode) a_merr++;
    if (b_rd_en) begin
      if (int'(b_raddr) != exp_ra(b_rd, 28, 28, 2, 14, 14)) b_err++;
      b_last_ra = int'(b_raddr);
      b_rd++;
    end
    if (b_clr) begin
      if (b_f_clr < 0) b_f_clr = cyc_n;
      b_clr_n++;
    end
    if (b_wr_en) begin
      if (b_f_wr < 0) b_f_wr = cyc_n;
      if (int'(b_waddr) != b_wr) b_err++;
      b_last_wa = int'(b_waddr);
      b_last_wr = cyc_n;
      b_wr++;
    end
    if (b_done_o) begin b_dn++; b_done_cyc = cyc_n; end
  endtask

  task automatic start_a(input logic m);
    clr_stats();
    a_mode = m;
    a_exp_mode = m;
    a_start = 1'b1;
    cyc_n = 0;
    cyc();
    a_start = 1'b0;
    chk("a_busy_after_start", a_busy, 1);
  endtask

  task automatic wait_done_a(input int budget);
    int i;
    i = 0;
    while (a_dn == 0 && i < budget) begin cyc(); i++; end
    repeat (5) cyc();
  endtask

  task automatic check_full_a(input string t);
    chk({t, "_done_seen"}, a_dn, 1);
    chk({t, "_rd_total"}, a_rd, 1600);
    chk({t, "_wr_total"}, a_wr, 400);
    chk({t, "_clr_total"}, a_clr_n, 400);
    chk({t, "_seq_err"}, a_err, 0);
    chk({t, "_last_waddr"}, a_last_wa, 399);
    chk({t, "_done_after_wr"}, a_done_cyc, a_last_wr + 1);
    chk({t, "_mode_hold"}, a_merr, 0);
    chk({t, "_idle_busy"}, a_busy, 0);
  endtask

  task automatic check_head_a(input string t);
    int exp8 [8];
    exp8 = '{0, 1, 10, 11, 2, 3, 12, 13};
    for (int i = 0; i < 8; i++) chk({t, "_raddr_head"}, a_ra[i], exp8[i]);
    chk({t, "_first_clr_cyc"}, a_f_clr, 3);
    chk({t, "_first_wr_cyc"}, a_f_wr, 7);
    chk({t, "_first_waddr"}, a_f_wa, 0);
  endtask

  initial begin
    int i, left, prev_st, st_err;
    rst_n = 1'b0;
    a_start = 0; a_mode = 0; a_stall = 0; a_abort = 0;
    b_start = 0; b_mode = 0; b_stall = 0; b_abort = 0;
    a_exp_mode = 0;
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_rd_en", a_rd_en, 0);
    chk("rst_a_raddr", a_raddr, 0);
    chk("rst_a_wr_en", a_wr_en, 0);
    chk("rst_a_clr", a_clr, 0);
    chk("rst_a_done", a_done_o, 0);
    chk("rst_a_mode_o", a_mode_o, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_rd_en", b_rd_en, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_stall_busy", a_busy, 0);

    // 1: plain run
    start_a(1'b0);
    wait_done_a(2000);
    check_full_a("t1");
    check_head_a("t1");

    // 2: stall 3 cycles after every 7th issue
    start_a(1'b0);
    left = 0; prev_st = 0; st_err = 0; i = 0;
    while (a_dn == 0 && i < 4000) begin
      prev_st = a_stall;
      cyc();
      i++;
      if (prev_st && a_rd_en) st_err++;
      if (left > 0) begin
        left--;
        if (left == 0) a_stall = 1'b0;
      end else if (a_rd_en && (a_rd % 7) == 0) begin
        a_stall = 1'b1;
        left = 3;
      end
    end
    a_stall = 1'b0;
    repeat (5) cyc();
    check_full_a("t2");
    chk("t2_stall_blocks_rd", st_err, 0);
    chk("t2_stretched", (a_done_cyc > 1604) ? 1 : 0, 1);

    // 3: second start mid-run with flipped mode
    start_a(1'b1);
    i = 0;
    while (a_dn == 0 && i < 2000) begin
      cyc();
      i++;
      if (cyc_n == 50) begin a_start = 1'b1; a_mode = 1'b0; end
      if (cyc_n == 51) a_start = 1'b0;
    end
    repeat (5) cyc();
    check_full_a("t3");
    chk("t3_mode_kept", a_mode_o, 1);

    // 4: abort after 100 issues, then a fresh run
    start_a(1'b0);
    i = 0;
    while (a_rd < 100 && i < 500) begin cyc(); i++; end
    a_abort = 1'b1;
    cyc();
    a_abort = 1'b0;
    chk("t4_busy_drop", a_busy, 0);
    chk("t4_rd_en_off", a_rd_en, 0);
    repeat (20) cyc();
    chk("t4_rd_total", a_rd, 100);
    chk("t4_wr_total", a_wr, 24);
    chk("t4_clr_total", a_clr_n, 25);
    chk("t4_no_done", a_dn, 0);
    chk("t4_seq_err", a_err, 0);
    start_a(1'b0);
    wait_done_a(2000);
    check_full_a("t4b");
    check_head_a("t4b");

    // 5: reset mid-run
    start_a(1'b1);
    repeat (30) cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", a_busy, 0);
    chk("t5_rd_en", a_rd_en, 0);
    chk("t5_raddr", a_raddr, 0);
    chk("t5_wr_en", a_wr_en, 0);
    chk("t5_waddr", a_waddr, 0);
    chk("t5_clr", a_clr, 0);
    chk("t5_mode_o", a_mode_o, 0);
    chk("t5_done", a_done_o, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("t5_idle", a_busy, 0);
    start_a(1'b0);
    wait_done_a(2000);
    check_full_a("t5");
    check_head_a("t5");

    // 6: 28x28, 6 channels, RD_LAT=2
    clr_stats();
    b_start = 1'b1;
    cyc_n = 0;
    cyc();
    b_start = 1'b0;
    i = 0;
    while (b_dn == 0 && i < 6000) begin cyc(); i++; end
    repeat (5) cyc();
    chk("t6_done_seen", b_dn, 1);
    chk("t6_rd_total", b_rd, 4704);
    chk("t6_wr_total", b_wr, 1176);
    chk("t6_clr_total", b_clr_n, 1176);
    chk("t6_last_raddr", b_last_ra, 4703);
    chk("t6_last_waddr", b_last_wa, 1175);
    chk("t6_first_clr_cyc", b_f_clr, 4);
    chk("t6_first_wr_cyc", b_f_wr, 8);
    chk("t6_done_after_wr", b_done_cyc, b_last_wr + 1);
    chk("t6_seq_err", b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
